// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the stopwatch controller:
//   - sw_state_t : sequencer states (IDLE, RUN, PAUSE)
//   - CS_MAX / SEC_MAX / MIN_MAX : BCD roll-over limits of each time field
//   - bcd_time_t / TIME_W : packed mm:ss.cc BCD time value and its width
//   - bcd_inc() : two-digit BCD increment with roll-over flag
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_t;

   localparam logic [7:0] CS_MAX  = 8'h99;
   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;

   typedef struct packed {
      logic [7:0] min;
      logic [7:0] sec;
      logic [7:0] cs;
   } bcd_time_t;

   localparam int TIME_W = $bits(bcd_time_t);

   // Returns {wrap, next}: wrap is set when v sits at max and rolls to 00.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [8:0] r;
      if (v == max) begin
         r = {1'b1, 8'h00};
      end else if (v[3:0] == 4'd9) begin
         r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {1'b0, v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/sw_btn_pulse.sv
// sw_btn_pulse
//   Brings one asynchronous, already-debounced button into the clk domain
//   and turns each press into a single-cycle pulse.
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-high reset
//     btn   in  raw button level (asynchronous)
//     pulse out one clk wide on each rising edge of btn (2 flops of sync,
//               then an edge detect), regardless of how long btn is held
module sw_btn_pulse (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign pulse = sync2 & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/clear/lap sequencer for the stopwatch core. Buttons become
//   single pulses, a three-state FSM gates a prescaler and a BCD mm:ss.cc
//   counter, and a lap register can freeze the display while counting goes on.
//   Parameters:
//     CLK_HZ, TICK_HZ : clock and count rate; DIV = CLK_HZ/TICK_HZ (>= 2)
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     start, clear, lap             raw asynchronous buttons, active-high
//     disp_min, disp_sec, disp_cs   registered BCD display value
//     running                       1 while in RUN
//     lap_active                    1 while the display shows the lap value
//     ovf                           sticky, set when 59:59.99 rolls to 00:00.00
//   Handshake: none; button pulses are fire-and-forget one-cycle strobes.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clear,
   input  logic       lap,
   output logic [7:0] disp_min,
   output logic [7:0] disp_sec,
   output logic [7:0] disp_cs,
   output logic       running,
   output logic       lap_active,
   output logic       ovf
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic start_p, clear_p, lap_p;

   sw_btn_pulse u_start (.clk(clk), .rst(rst), .btn(start), .pulse(start_p));
   sw_btn_pulse u_clear (.clk(clk), .rst(rst), .btn(clear), .pulse(clear_p));
   sw_btn_pulse u_lap   (.clk(clk), .rst(rst), .btn(lap),   .pulse(lap_p));

   sw_state_t       state_q, state_d;
   logic [PW-1:0]   presc_q;
   logic [TIME_W-1:0] cnt_q;
   bcd_time_t       cnt_t;
   bcd_time_t       cnt_inc;
   bcd_time_t       lap_q;
   bcd_time_t       disp_q;
   logic            lap_active_q;
   logic            ovf_q;
   logic            running_q;
   logic            zero_all;
   logic            lap_toggle;
   logic            tick;
   logic            cs_wrap, sec_wrap, min_wrap;
   logic [7:0]      cs_n, sec_n, min_n;

   assign cnt_t = bcd_time_t'(cnt_q);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and control strobes
   always_comb begin
      state_d    = state_q;
      lap_toggle = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_p) state_d = ST_RUN;
         end
         ST_RUN: begin
            // clear is deliberately ignored while running
            if (start_p) state_d = ST_PAUSE;
            lap_toggle = lap_p;
         end
         ST_PAUSE: begin
            // clear wins over start so a clear+start lands in IDLE
            if (clear_p)      state_d = ST_IDLE;
            else if (start_p) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Every cycle spent in (or entering) IDLE holds the datapath at zero.
   assign zero_all = (state_d == ST_IDLE);
   assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

   // BCD cascade: each field only advances when the one below rolls over.
   assign {cs_wrap,  cs_n}  = bcd_inc(cnt_t.cs,  CS_MAX);
   assign {sec_wrap, sec_n} = bcd_inc(cnt_t.sec, SEC_MAX);
   assign {min_wrap, min_n} = bcd_inc(cnt_t.min, MIN_MAX);

   always_comb begin
      cnt_inc    = cnt_t;
      cnt_inc.cs = cs_n;
      if (cs_wrap) begin
         cnt_inc.sec = sec_n;
         if (sec_wrap) cnt_inc.min = min_n;
      end
   end

   // Datapath: prescaler, time counter, lap register, flags, display
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q      <= '0;
         cnt_q        <= '0;
         lap_q        <= '0;
         lap_active_q <= 1'b0;
         ovf_q        <= 1'b0;
         running_q    <= 1'b0;
         disp_q       <= '0;
      end else begin
         running_q <= (state_d == ST_RUN);
         disp_q    <= lap_active_q ? lap_q : cnt_t;
         if (zero_all) begin
            presc_q      <= '0;
            cnt_q        <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            ovf_q        <= 1'b0;
         end else begin
            // Prescaler is only held (not zeroed) in PAUSE so a resume
            // keeps the partial centisecond already counted.
            if (state_q == ST_RUN) begin
               presc_q <= tick ? '0 : presc_q + PW'(1);
            end
            if (tick) begin
               cnt_q <= cnt_inc;
               if (cs_wrap && sec_wrap && min_wrap) ovf_q <= 1'b1;
            end
            if (lap_toggle) begin
               if (!lap_active_q) begin
                  lap_q        <= cnt_t;
                  lap_active_q <= 1'b1;
               end else begin
                  lap_active_q <= 1'b0;
               end
            end
         end
      end
   end

   assign disp_min   = disp_q.min;
   assign disp_sec   = disp_q.sec;
   assign disp_cs    = disp_q.cs;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign ovf        = ovf_q;

endmodule
